// File: rtl/nx1_slot_host.sv
// -----------------------------------------------------------------------------
// nx1_slot_host
//   Initiator side of the x1 expansion slot bus. Turns one CPU-side request
//   (memory or io, read or write) into a complete slot bus cycle:
//     IDLE -> SETUP -> STROBE -> [WAIT] -> HOLD -> DONE -> IDLE
//   Cards may stretch the cycle with slot_exwait_n, shorten the strobe with
//   slot_fastcycle, and a wait timeout forces completion with open-bus data.
//
// Ports
//   slot_sysclk      system clock
//   slot_reset_n     asynchronous active-low reset
//   slot_syscke      tick enable; every state/counter update waits for it,
//                    except DONE, which lasts exactly one sysclk
//   cpu_req/we/io/m1 request level and attributes, held until cpu_ack
//   cpu_addr/wdata   request address / write data
//   cpu_rdata        read data, valid with cpu_ack (unchanged by writes)
//   cpu_ack          one-sysclk completion pulse
//   cpu_timeout      sticky flag: some cycle ended by timeout
//   slot_addr/wdata  slot address / write data, held from SETUP to DONE
//   slot_mreq_n, slot_ioreq_n, slot_rd_n, slot_wr_n, slot_m1_n  slot strobes
//   slot_exio        io cycle active on the slot
//   slot_rdata/valid card read data and its valid qualifier
//   slot_exwait_n    card wait request (low = stretch)
//   slot_fastcycle   card asks for a one-tick strobe
// -----------------------------------------------------------------------------
module nx1_slot_host #(
  parameter int          P_STROBE  = 2,
  parameter int          P_TIMEOUT = 255,
  parameter logic [7:0]  P_OPENBUS = 8'hFF
) (
  input  logic        slot_sysclk,
  input  logic        slot_reset_n,
  input  logic        slot_syscke,
  input  logic        cpu_req,
  input  logic        cpu_we,
  input  logic        cpu_io,
  input  logic        cpu_m1,
  input  logic [15:0] cpu_addr,
  input  logic [7:0]  cpu_wdata,
  output logic [7:0]  cpu_rdata,
  output logic        cpu_ack,
  output logic        cpu_timeout,
  output logic [15:0] slot_addr,
  output logic [7:0]  slot_wdata,
  output logic        slot_mreq_n,
  output logic        slot_ioreq_n,
  output logic        slot_rd_n,
  output logic        slot_wr_n,
  output logic        slot_m1_n,
  output logic        slot_exio,
  input  logic [7:0]  slot_rdata,
  input  logic        slot_valid,
  input  logic        slot_exwait_n,
  input  logic        slot_fastcycle
);

  // Strobe counter holds 0..P_STROBE-1; wait counter is at least 8 bits and
  // wide enough to reach P_TIMEOUT.
  localparam int SCW = (P_STROBE > 1) ? $clog2(P_STROBE) : 1;
  localparam int WCW = ($clog2(P_TIMEOUT + 1) > 8) ? $clog2(P_TIMEOUT + 1) : 8;

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETUP,
    S_STROBE,
    S_WAIT,
    S_HOLD,
    S_DONE
  } state_t;

  state_t          state_q, state_d;
  logic [15:0]     addr_q;
  logic [7:0]      wdata_q;
  logic            we_q, io_q, m1_q;
  logic [SCW-1:0]  scnt_q, scnt_d;
  logic [WCW-1:0]  wcnt_q, wcnt_d;
  logic            tmo_q, tmo_d;        // this cycle is ending by timeout
  logic [7:0]      rdata_q, rdata_d;
  logic            timeout_q, timeout_d;
  logic            latch_en;

  logic [WCW-1:0]  wcnt_inc;
  logic [7:0]      cap_data;
  logic            strobe_end;

  assign cap_data = slot_valid ? slot_rdata : P_OPENBUS;
  // Saturating increment so a huge P_TIMEOUT can never wrap the counter.
  assign wcnt_inc = (wcnt_q == '1) ? wcnt_q : wcnt_q + WCW'(1);
  // Fast cycles are only honoured on the first strobe tick.
  assign strobe_end = ((scnt_q == '0) && slot_fastcycle) ||
                      (scnt_q == SCW'(P_STROBE - 1));

  always_comb begin
    state_d   = state_q;
    scnt_d    = scnt_q;
    wcnt_d    = wcnt_q;
    tmo_d     = tmo_q;
    rdata_d   = rdata_q;
    timeout_d = timeout_q;
    latch_en  = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (slot_syscke && cpu_req) begin
          latch_en = 1'b1;
          state_d  = S_SETUP;
        end
      end

      S_SETUP: begin
        if (slot_syscke) begin
          scnt_d  = '0;
          wcnt_d  = '0;
          tmo_d   = 1'b0;
          state_d = S_STROBE;
        end
      end

      S_STROBE: begin
        if (slot_syscke) begin
          if (strobe_end) begin
            if (!slot_exwait_n) begin
              state_d = S_WAIT;
            end else begin
              state_d = S_HOLD;
              // Read data is sampled while rd_n is still low.
              if (!we_q) rdata_d = cap_data;
            end
          end else begin
            scnt_d = scnt_q + SCW'(1);
          end
        end
      end

      S_WAIT: begin
        if (slot_syscke) begin
          // A released wait wins over a timeout on the same tick.
          if (slot_exwait_n) begin
            state_d = S_HOLD;
            if (!we_q) rdata_d = cap_data;
          end else begin
            wcnt_d = wcnt_inc;
            if (wcnt_inc >= WCW'(P_TIMEOUT)) begin
              state_d = S_HOLD;
              tmo_d   = 1'b1;
              if (!we_q) rdata_d = P_OPENBUS;
            end
          end
        end
      end

      S_HOLD: begin
        if (slot_syscke) begin
          state_d = S_DONE;
          if (tmo_q) timeout_d = 1'b1;
        end
      end

      S_DONE: begin
        // Ack is a single sysclk regardless of the tick enable.
        state_d = S_IDLE;
      end

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge slot_sysclk or negedge slot_reset_n) begin
    if (!slot_reset_n) begin
      state_q   <= S_IDLE;
      addr_q    <= '0;
      wdata_q   <= '0;
      we_q      <= 1'b0;
      io_q      <= 1'b0;
      m1_q      <= 1'b0;
      scnt_q    <= '0;
      wcnt_q    <= '0;
      tmo_q     <= 1'b0;
      rdata_q   <= '0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      scnt_q    <= scnt_d;
      wcnt_q    <= wcnt_d;
      tmo_q     <= tmo_d;
      rdata_q   <= rdata_d;
      timeout_q <= timeout_d;
      if (latch_en) begin
        addr_q  <= cpu_addr;
        wdata_q <= cpu_wdata;
        we_q    <= cpu_we;
        io_q    <= cpu_io;
        m1_q    <= cpu_m1;
      end
    end
  end

  // Output decode from registered state only, so the async reset pulls
  // every strobe inactive in the same cycle it is asserted.
  logic strobe_on, cyc_on;
  assign strobe_on = (state_q == S_STROBE) || (state_q == S_WAIT);
  assign cyc_on    = (state_q == S_SETUP) || strobe_on;

  assign slot_mreq_n  = ~(strobe_on & ~io_q);
  assign slot_ioreq_n = ~(strobe_on &  io_q);
  assign slot_rd_n    = ~(strobe_on & ~we_q);
  assign slot_wr_n    = ~(strobe_on &  we_q);
  assign slot_m1_n    = ~(cyc_on & m1_q);
  assign slot_exio    = cyc_on & io_q;
  assign slot_addr    = addr_q;
  assign slot_wdata   = wdata_q;
  assign cpu_rdata    = rdata_q;
  assign cpu_ack      = (state_q == S_DONE);
  assign cpu_timeout  = timeout_q;

endmodule

// File: tb/tb_nx1_slot_host.sv
// -----------------------------------------------------------------------------
// tb_nx1_slot_host
//   Randomised bench for nx1_slot_host. A transaction-level model predicts,
//   per cycle request, how many ticks the strobes stay low, the read data and
//   the timeout flag; a monitor process checks the bus every cycle against it.
//   Directed transactions additionally carry hand-computed literal results.
// -----------------------------------------------------------------------------
module tb_nx1_slot_host;
  localparam int P_STROBE  = 2;
  localparam int P_TIMEOUT = 255;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        syscke = 1'b0;
  logic        req = 1'b0, we = 1'b0, io = 1'b0, m1 = 1'b0;
  logic [15:0] addr = '0;
  logic [7:0]  wdata = '0, srdata = '0;
  logic        svalid = 1'b0, exwait_n = 1'b1, fast = 1'b0;

  logic [7:0]  cpu_rdata;
  logic        cpu_ack, cpu_timeout;
  logic [15:0] slot_addr;
  logic [7:0]  slot_wdata;
  logic        mreq_n, ioreq_n, rd_n, wr_n, m1_n, exio;

  nx1_slot_host dut (
    .slot_sysclk   (clk),
    .slot_reset_n  (rst_n),
    .slot_syscke   (syscke),
    .cpu_req       (req),
    .cpu_we        (we),
    .cpu_io        (io),
    .cpu_m1        (m1),
    .cpu_addr      (addr),
    .cpu_wdata     (wdata),
    .cpu_rdata     (cpu_rdata),
    .cpu_ack       (cpu_ack),
    .cpu_timeout   (cpu_timeout),
    .slot_addr     (slot_addr),
    .slot_wdata    (slot_wdata),
    .slot_mreq_n   (mreq_n),
    .slot_ioreq_n  (ioreq_n),
    .slot_rd_n     (rd_n),
    .slot_wr_n     (wr_n),
    .slot_m1_n     (m1_n),
    .slot_exio     (exio),
    .slot_rdata    (srdata),
    .slot_valid    (svalid),
    .slot_exwait_n (exwait_n),
    .slot_fastcycle(fast)
  );

  always #5 clk = ~clk;

  // Monitor-owned
  int checks = 0;
  int errors = 0;
  int low_ticks = 0;
  int ack_count = 0;
  int acked_id = -1;
  logic prev_ack = 1'b0;

  // Driver-owned expectations
  logic       txn_active = 1'b0;
  int         txn_id = 0;
  int         cur_l = 0;
  int         exp_low = 0;
  logic [7:0] exp_rdata = 8'h00;   // model of cpu_rdata after the current txn
  logic       exp_sticky = 1'b0;   // model of cpu_timeout
  logic       lit_valid = 1'b0;
  int         lit_low = 0;
  logic [7:0] lit_rdata = 8'h00;
  logic       lit_to = 1'b0;
  logic       bound_expired = 1'b0;

  task automatic chk(input string name, input int act, input int expv);
    checks++;
    if (act != expv) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, expv, $time);
    end
  endtask

  // Monitor: samples on the falling edge, away from the active edge.
  initial begin
    logic strobe_low;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        chk("rst_strobes", {mreq_n, ioreq_n, rd_n, wr_n, m1_n}, 5'h1F);
        chk("rst_exio", exio, 0);
        chk("rst_addr", slot_addr, 0);
        chk("rst_wdata", slot_wdata, 0);
        chk("rst_rdata", cpu_rdata, 0);
        chk("rst_ack", cpu_ack, 0);
        chk("rst_timeout", cpu_timeout, 0);
        low_ticks = 0;
        prev_ack = 1'b0;
      end else begin
        if (bound_expired) begin
          checks++;
          errors++;
          $display("FAIL ack_wait_bound actual=no_ack required=ack txn=%0d", txn_id);
        end
        strobe_low = !mreq_n || !ioreq_n || !rd_n || !wr_n;
        if (strobe_low) begin
          if (!txn_active) begin
            chk("stray_strobe", strobe_low, 0);
          end else begin
            chk("mreq_ioreq", {mreq_n, ioreq_n}, io ? 2'b10 : 2'b01);
            chk("rd_wr", {rd_n, wr_n}, we ? 2'b10 : 2'b01);
            chk("addr_held", slot_addr, addr);
            chk("wdata_held", slot_wdata, wdata);
            chk("exio", exio, io);
            chk("m1_n", m1_n, !m1);
          end
          if (syscke) low_ticks++;
        end
        if (cpu_ack) begin
          chk("ack_in_txn", txn_active, 1);
          chk("single_ack", acked_id == txn_id, 0);
          chk("ack_width", prev_ack, 0);
          chk("ack_bus_idle", {strobe_low, exio, !m1_n}, 0);
          chk("strobe_ticks", low_ticks, exp_low);
          chk("rdata", cpu_rdata, exp_rdata);
          chk("timeout", cpu_timeout, exp_sticky);
          if (lit_valid) begin
            chk("lit_strobe_ticks", low_ticks, lit_low);
            chk("lit_rdata", cpu_rdata, lit_rdata);
            chk("lit_timeout", cpu_timeout, lit_to);
          end
          acked_id = txn_id;
          ack_count++;
          low_ticks = 0;
        end else if (!txn_active) begin
          chk("idle_timeout", cpu_timeout, exp_sticky);
        end
        prev_ack = cpu_ack;
      end
    end
  end

  // One clock: inputs change 1 time unit after the active edge.
  task automatic step();
    @(posedge clk);
    #1;
    syscke   = ($urandom_range(0, 3) != 0);
    // The card holds exwait_n low until the strobes have been low cur_l ticks.
    exwait_n = (low_ticks < cur_l) ? 1'b0 : 1'b1;
  endtask

  task automatic run_txn(input logic t_we, input logic t_io, input logic t_m1,
                         input logic [15:0] t_addr, input logic [7:0] t_wdata,
                         input logic [7:0] t_rdata, input logic t_valid,
                         input logic t_fast, input int t_l, input logic t_drop,
                         input logic t_lit, input int l_low,
                         input logic [7:0] l_rdata, input logic l_to);
    int s;
    int start;
    logic to;
    // Transaction-level model
    s = t_fast ? 1 : P_STROBE;
    if (t_l < s) begin
      exp_low = s; to = 1'b0;
    end else if (t_l - s + 1 <= P_TIMEOUT) begin
      exp_low = t_l + 1; to = 1'b0;
    end else begin
      exp_low = s + P_TIMEOUT; to = 1'b1;
    end
    if (!t_we) exp_rdata = to ? 8'hFF : (t_valid ? t_rdata : 8'hFF);
    if (to) exp_sticky = 1'b1;
    lit_valid = t_lit; lit_low = l_low; lit_rdata = l_rdata; lit_to = l_to;

    we = t_we; io = t_io; m1 = t_m1; addr = t_addr; wdata = t_wdata;
    srdata = t_rdata; svalid = t_valid; fast = t_fast; cur_l = t_l;
    txn_id++;
    txn_active = 1'b1;
    req = 1'b1;
    start = ack_count;
    for (int n = 0; n < 3000; n++) begin
      step();
      if (t_drop && low_ticks >= 1) req = 1'b0;
      if (ack_count != start) break;
    end
    if (ack_count == start) begin
      bound_expired = 1'b1;
      step();
      bound_expired = 1'b0;
    end
    req = 1'b0;
    txn_active = 1'b0;
    lit_valid = 1'b0;
    $display("txn %0d we=%0d io=%0d addr=%04h wait=%0d fast=%0d low_ticks=%0d rdata=%02h to=%0d",
             txn_id, t_we, t_io, t_addr, t_l, t_fast, exp_low, exp_rdata, exp_sticky);
    for (int i = 0; i < int'($urandom_range(0, 2)); i++) step();
  endtask

  initial begin
    int r;
    int wait_l;
    for (int i = 0; i < 3; i++) step();
    rst_n = 1'b1;
    for (int i = 0; i < 2; i++) step();

    // Directed cases with literal results
    run_txn(0, 1, 0, 16'h0700, 8'h00, 8'h03, 1, 0, 0, 0, 1, 2, 8'h03, 0);
    run_txn(1, 0, 1, 16'h1234, 8'h5A, 8'h77, 1, 0, 6, 0, 1, 7, 8'h03, 0);
    run_txn(0, 1, 0, 16'h0701, 8'h00, 8'h55, 0, 0, 0, 0, 1, 2, 8'hFF, 0);
    run_txn(0, 1, 0, 16'h0702, 8'h00, 8'h41, 1, 1, 0, 0, 1, 1, 8'h41, 0);
    run_txn(0, 0, 0, 16'h8000, 8'h00, 8'h99, 1, 0, 100000, 0, 1, 257, 8'hFF, 1);

    // Reset while the card holds the cycle in WAIT
    we = 1'b0; io = 1'b1; m1 = 1'b0; addr = 16'h0C00; wdata = 8'h00;
    srdata = 8'h12; svalid = 1'b1; fast = 1'b0; cur_l = 100000;
    txn_id++;
    txn_active = 1'b1;
    req = 1'b1;
    for (int n = 0; n < 200 && low_ticks < 5; n++) step();
    rst_n = 1'b0;
    txn_active = 1'b0;
    req = 1'b0;
    exp_sticky = 1'b0;
    exp_rdata = 8'h00;
    $display("reset asserted during WAIT at low_ticks=%0d", low_ticks);
    for (int i = 0; i < 3; i++) step();
    rst_n = 1'b1;
    step();

    // Randomised traffic
    for (int t = 0; t < 40; t++) begin
      r = int'($urandom_range(0, 9));
      wait_l = (r < 4) ? 0 : r - 2;
      run_txn(logic'($urandom_range(0, 1)), logic'($urandom_range(0, 1)),
              logic'($urandom_range(0, 1)), 16'($urandom), 8'($urandom),
              8'($urandom), ($urandom_range(0, 3) != 0),
              ($urandom_range(0, 3) == 0), wait_l,
              ($urandom_range(0, 3) == 0), 0, 0, 8'h00, 0);
    end

    for (int i = 0; i < 3; i++) step();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
